// File: rtl/m_mem_access_wreg.sv
// M-stage memory access controller and M/W pipeline register.
// Merges sub-word stores into full-word writes, aligns/extends loads,
// flags misaligned accesses and registers the result into the W stage.
module m_mem_access_wreg #(
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             M_stall,
    input  logic             M_flush,
    input  logic             M_valid,
    input  logic [3:0]       M_op,
    input  logic [31:0]      M_addr,
    input  logic [31:0]      M_rt_data,
    input  logic [31:0]      M_alu_res,
    input  logic [31:0]      M_pc,
    input  logic [4:0]       M_wa,
    input  logic             M_reg_we,
    input  logic [31:0]      DM_rdata,
    output logic             DM_we,
    output logic [31:0]      DM_addr,
    output logic [31:0]      DM_wdata,
    output logic             W_valid,
    output logic [31:0]      W_pc,
    output logic [4:0]       W_wa,
    output logic             W_reg_we,
    output logic [31:0]      W_wdata,
    output logic             W_exc,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    logic        is_store;
    logic        mis;
    logic        st_done;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] merged;
    logic [31:0] wb_data;

    // Decode store class and alignment fault.
    always_comb begin
        is_store = 1'b0;
        mis      = 1'b0;
        case (M_op)
            OP_LW:                mis = |M_addr[1:0];
            OP_LH, OP_LHU:        mis = M_addr[0];
            OP_SW: begin
                is_store = 1'b1;
                mis      = |M_addr[1:0];
            end
            OP_SH: begin
                is_store = 1'b1;
                mis      = M_addr[0];
            end
            OP_SB:                is_store = 1'b1;
            default: ;
        endcase
    end

    // Read-modify-write merge of the store operand into the current word.
    always_comb begin
        merged = DM_rdata;
        case (M_op)
            OP_SW:   merged = M_rt_data;
            OP_SH:   merged[{M_addr[1], 4'b0000} +: 16] = M_rt_data[15:0];
            OP_SB:   merged[{M_addr[1:0], 3'b000} +: 8] = M_rt_data[7:0];
            default: ;
        endcase
    end

    // Select and extend load data; non-loads forward the ALU result.
    always_comb begin
        byte_sel = DM_rdata[{M_addr[1:0], 3'b000} +: 8];
        half_sel = DM_rdata[{M_addr[1], 4'b0000} +: 16];
        case (M_op)
            OP_LW:   wb_data = DM_rdata;
            OP_LH:   wb_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  wb_data = {16'h0000, half_sel};
            OP_LB:   wb_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  wb_data = {24'h000000, byte_sel};
            default: wb_data = M_alu_res;
        endcase
    end

    assign DM_we    = rst & M_valid & is_store & ~mis & ~M_flush & ~st_done;
    assign DM_addr  = {M_addr[31:2], 2'b00};
    assign DM_wdata = merged;

    // Remember that a stalled store already wrote, so it writes only once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_done <= 1'b0;
        end else if (M_flush || !M_stall) begin
            st_done <= 1'b0;
        end else if (DM_we) begin
            st_done <= 1'b1;
        end
    end

    // M/W pipeline register: flush beats stall beats advance.
    always_ff @(posedge clk) begin
        if (!rst || M_flush) begin
            W_valid  <= 1'b0;
            W_pc     <= 32'h0;
            W_wa     <= 5'h0;
            W_reg_we <= 1'b0;
            W_wdata  <= 32'h0;
            W_exc    <= 1'b0;
        end else if (!M_stall) begin
            W_valid  <= M_valid;
            W_pc     <= M_pc;
            W_wa     <= M_wa;
            W_reg_we <= M_valid & M_reg_we & ~mis;
            W_wdata  <= wb_data;
            W_exc    <= M_valid & mis;
        end
    end

    // Saturating count of misaligned accesses that actually advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (!M_flush && !M_stall && M_valid && mis && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_m_mem_access_wreg.sv
// Scoreboard bench for m_mem_access_wreg with a behavioural data memory.
module tb_m_mem_access_wreg;

    logic        clk = 1'b0;
    logic        rst;
    logic        M_stall, M_flush, M_valid, M_reg_we;
    logic [3:0]  M_op;
    logic [31:0] M_addr, M_rt_data, M_alu_res, M_pc;
    logic [4:0]  M_wa;
    logic [31:0] DM_rdata;
    logic        DM_we;
    logic [31:0] DM_addr, DM_wdata;
    logic        W_valid, W_reg_we, W_exc;
    logic [31:0] W_pc, W_wdata;
    logic [4:0]  W_wa;
    logic [7:0]  err_cnt;

    m_mem_access_wreg #(.ERR_W(8)) dut (
        .clk(clk), .rst(rst), .M_stall(M_stall), .M_flush(M_flush),
        .M_valid(M_valid), .M_op(M_op), .M_addr(M_addr), .M_rt_data(M_rt_data),
        .M_alu_res(M_alu_res), .M_pc(M_pc), .M_wa(M_wa), .M_reg_we(M_reg_we),
        .DM_rdata(DM_rdata), .DM_we(DM_we), .DM_addr(DM_addr), .DM_wdata(DM_wdata),
        .W_valid(W_valid), .W_pc(W_pc), .W_wa(W_wa), .W_reg_we(W_reg_we),
        .W_wdata(W_wdata), .W_exc(W_exc), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    int          we_cnt = 0;

    assign DM_rdata = mem[DM_addr[13:2]];

    always @(posedge clk) begin
        if (DM_we) begin
            mem[DM_addr[13:2]] <= DM_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  wa;
        logic        reg_we;
        logic [31:0] wdata;
        logic        exc;
    } w_t;

    w_t          sb_q[$];
    w_t          w_model;
    int          exp_err;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cur_pc = 32'h0000_1000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one M-cycle, check the memory side mid-cycle, then the W side after the edge.
    task automatic issue(input logic v, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, input logic stall, input logic flush,
                         input logic exp_we);
        logic        is_ld, is_st, mis;
        logic [31:0] word, ld, mg, sh_amt;
        w_t          nxt, got;
        is_ld = (op >= 4'd1) && (op <= 4'd5);
        is_st = (op >= 4'd6) && (op <= 4'd8);
        mis = ((op == 4'd1 || op == 4'd6) && addr[1:0] != 2'b00) ||
              ((op == 4'd2 || op == 4'd3 || op == 4'd7) && addr[0]);
        M_valid = v; M_op = op; M_addr = addr; M_rt_data = rt;
        M_alu_res = cur_pc ^ 32'hA5A5_0000; M_pc = cur_pc; M_wa = cur_pc[6:2];
        M_reg_we = !is_st; M_stall = stall; M_flush = flush;

        word = ref_mem[addr[13:2]];
        case (op)
            4'd1: ld = word;
            4'd2, 4'd3: begin
                sh_amt = addr[1] ? 32'd16 : 32'd0;
                ld = (word >> sh_amt) & 32'h0000_FFFF;
                if (op == 4'd2 && ld[15]) ld = ld | 32'hFFFF_0000;
            end
            4'd4, 4'd5: begin
                sh_amt = 32'(addr[1:0]) * 32'd8;
                ld = (word >> sh_amt) & 32'h0000_00FF;
                if (op == 4'd4 && ld[7]) ld = ld | 32'hFFFF_FF00;
            end
            default: ld = M_alu_res;
        endcase

        if (flush) nxt = '0;
        else if (stall) nxt = w_model;
        else begin
            nxt = '{valid: v, pc: cur_pc, wa: cur_pc[6:2], reg_we: v & !is_st & !mis,
                    wdata: ld, exc: v & mis};
            if (v && mis && exp_err < 255) exp_err++;
        end
        sb_q.push_back(nxt);
        w_model = nxt;

        @(negedge clk);
        chk("dm_we", 32'(DM_we), 32'(exp_we));
        if (exp_we) begin
            case (op)
                4'd8: begin
                    sh_amt = 32'(addr[1:0]) * 32'd8;
                    mg = (word & ~(32'hFF << sh_amt)) | ((rt & 32'hFF) << sh_amt);
                end
                4'd7: begin
                    sh_amt = addr[1] ? 32'd16 : 32'd0;
                    mg = (word & ~(32'hFFFF << sh_amt)) | ((rt & 32'hFFFF) << sh_amt);
                end
                default: mg = rt;
            endcase
            chk("dm_wdata", DM_wdata, mg);
            chk("dm_addr", DM_addr, addr & 32'hFFFF_FFFC);
            ref_mem[addr[13:2]] = mg;
        end

        @(posedge clk); #1;
        got = '{valid: W_valid, pc: W_pc, wa: W_wa, reg_we: W_reg_we, wdata: W_wdata, exc: W_exc};
        nxt = sb_q.pop_front();
        chk("w_valid", 32'(got.valid), 32'(nxt.valid));
        chk("w_pc", got.pc, nxt.pc);
        chk("w_wa", 32'(got.wa), 32'(nxt.wa));
        chk("w_reg_we", 32'(got.reg_we), 32'(nxt.reg_we));
        chk("w_wdata", got.wdata, nxt.wdata);
        chk("w_exc", 32'(got.exc), 32'(nxt.exc));
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        if (!stall) cur_pc = cur_pc + 32'd4;
    endtask

    // One cycle with reset asserted; memory write must be blocked and W cleared.
    task automatic reset_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dm_we", 32'(DM_we), 32'd0);
        @(posedge clk); #1;
        chk("rst_w_valid", 32'(W_valid), 32'd0);
        chk("rst_w_pc", W_pc, 32'd0);
        chk("rst_w_reg_we", 32'(W_reg_we), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        w_model = '0;
        exp_err = 0;
    endtask

    int we_before;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[4] = 32'h1122_3344;
        ref_mem[4] = 32'h1122_3344;
        M_stall = 0; M_flush = 0; M_valid = 1; M_op = 4'd6; M_addr = 32'h40;
        M_rt_data = 32'hDEAD_BEEF; M_alu_res = 0; M_pc = 0; M_wa = 0; M_reg_we = 0;
        w_model = '0; exp_err = 0;

        // Reset with a valid store presented.
        reset_cycle();
        reset_cycle();
        chk("rst_mem_untouched", mem[16], 32'h0);
        rst = 1'b1;

        // Byte store merge, then byte loads of the same location.
        issue(1, 4'd8, 32'h12, 32'h0000_00AB, 0, 0, 1);
        chk("sb_mem", mem[4], 32'h11AB_3344);
        issue(1, 4'd5, 32'h12, 0, 0, 0, 0);
        issue(1, 4'd4, 32'h12, 0, 0, 0, 0);
        issue(1, 4'd4, 32'h13, 0, 0, 0, 0);

        // Halfword store into an empty word, then halfword loads.
        issue(1, 4'd7, 32'h16, 32'h0000_8001, 0, 0, 1);
        issue(1, 4'd2, 32'h16, 0, 0, 0, 0);
        issue(1, 4'd3, 32'h16, 0, 0, 0, 0);
        issue(1, 4'd1, 32'h14, 0, 0, 0, 0);
        issue(1, 4'd2, 32'h10, 0, 0, 0, 0);

        // Misaligned load and store.
        issue(1, 4'd1, 32'h21, 0, 0, 0, 0);
        issue(1, 4'd7, 32'h23, 32'h1234, 0, 0, 0);

        // Unused opcode and an invalid slot behave as non-memory.
        issue(1, 4'd9, 32'h30, 32'h77, 0, 0, 0);
        issue(0, 4'd6, 32'h30, 32'h77, 0, 0, 0);

        // Store held across three stall cycles writes once.
        we_before = we_cnt;
        issue(1, 4'd6, 32'h30, 32'd5, 1, 0, 1);
        issue(1, 4'd6, 32'h30, 32'd5, 1, 0, 0);
        issue(1, 4'd6, 32'h30, 32'd5, 1, 0, 0);
        issue(1, 4'd6, 32'h30, 32'd5, 0, 0, 0);
        chk("stall_we_count", 32'(we_cnt - we_before), 32'd1);
        chk("stall_mem", mem[12], 32'd5);

        // Misaligned access under stall is not counted until it advances.
        issue(1, 4'd1, 32'h22, 0, 1, 0, 0);
        issue(1, 4'd1, 32'h22, 0, 0, 0, 0);

        // Flush beats stall: store suppressed, W bubbled, counter unchanged.
        issue(1, 4'd6, 32'h40, 32'h99, 0, 0, 1);
        issue(1, 4'd8, 32'h41, 32'hCD, 1, 1, 0);
        issue(1, 4'd1, 32'h41, 0, 0, 1, 0);
        issue(1, 4'd5, 32'h40, 0, 0, 0, 0);

        // Counter saturation.
        for (int i = 0; i < 260; i++) issue(1, 4'd1, 32'h21, 0, 0, 0, 0);
        chk("err_sat", 32'(err_cnt), 32'd255);

        // Reset in the middle of a stalled store, then the store retries.
        issue(1, 4'd8, 32'h50, 32'h11, 1, 0, 1);
        reset_cycle();
        rst = 1'b1;
        issue(1, 4'd8, 32'h50, 32'h22, 1, 0, 1);
        issue(1, 4'd8, 32'h50, 32'h22, 0, 0, 0);
        issue(1, 4'd5, 32'h50, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
